// File: rtl/riscv_mmio_uart_tx_if.sv
// CPU dmem-side bus bundle for the MMIO UART transmitter.
// The master drives address/strobe/data and the slave returns hit and read data.
interface riscv_mmio_uart_tx_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] i_uart_addr;
    logic            i_uart_wr_en;
    logic [3:0]      i_uart_byte_sel;
    logic [XLEN-1:0] i_uart_wr_data;
    logic            o_uart_hit;
    logic [XLEN-1:0] o_uart_rd_data;

    modport master (
        output i_uart_addr, i_uart_wr_en, i_uart_byte_sel, i_uart_wr_data,
        input  o_uart_hit, o_uart_rd_data
    );

    modport slave (
        input  i_uart_addr, i_uart_wr_en, i_uart_byte_sel, i_uart_wr_data,
        output o_uart_hit, o_uart_rd_data
    );
endinterface

// File: rtl/riscv_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable baud divider.
// Optional parity bit is enabled by defining UART_PARITY_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high; pops FIFO head into shift register when tx_en
// S_START  | start bit (0) for one bit time
// S_DATA   | 8 data bits, LSB first
// S_PARITY | parity bit (only with UART_PARITY_EN)
// S_STOP   | stop bit (1) for one bit time, then back to S_IDLE
module riscv_mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [15:0] CLK_DIV    = 16'd868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    riscv_mmio_uart_tx_if.slave    bus,
    output logic                   o_uart_txd,
    output logic                   o_uart_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   divisor;
    logic          tx_en, irq_en, parity_odd;
    logic [15:0]   timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [31:0]   rd_data;

    logic          hit, wr, push_req, push_ok, pop, full, empty, busy;
    logic [1:0]    reg_sel;
    logic [15:0]   div_m1;

    assign hit      = bus.i_uart_addr[31:4] == BASE_ADDR[31:4];
    assign reg_sel  = bus.i_uart_addr[3:2];
    assign wr       = bus.i_uart_wr_en & hit;
    assign push_req = wr & (reg_sel == 2'd0) & bus.i_uart_byte_sel[0];
    assign full     = count == (AW+1)'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign busy     = state != S_IDLE;
    assign pop      = (state == S_IDLE) & tx_en & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);
    assign div_m1   = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_req & full & ~pop)
                overflow <= 1'b1;
            else if (wr & (reg_sel == 2'd1) & bus.i_uart_byte_sel[0] & bus.i_uart_wr_data[3])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= bus.i_uart_wr_data[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            divisor    <= CLK_DIV;
            tx_en      <= 1'b1;
            irq_en     <= 1'b0;
            parity_odd <= 1'b0;
        end else if (wr) begin
            if (reg_sel == 2'd2) begin
                if (bus.i_uart_byte_sel[0]) divisor[7:0]  <= bus.i_uart_wr_data[7:0];
                if (bus.i_uart_byte_sel[1]) divisor[15:8] <= bus.i_uart_wr_data[15:8];
            end
            if ((reg_sel == 2'd3) && bus.i_uart_byte_sel[0]) begin
                tx_en  <= bus.i_uart_wr_data[0];
                irq_en <= bus.i_uart_wr_data[1];
`ifdef UART_PARITY_EN
                parity_odd <= bus.i_uart_wr_data[2];
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= S_IDLE;
            o_uart_txd <= 1'b1;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_uart_txd <= 1'b1;
                    if (pop) begin
                        state      <= S_START;
                        shreg      <= mem[rd_ptr];
                        par_bit    <= (^mem[rd_ptr]) ^ parity_odd;
                        o_uart_txd <= 1'b0;
                        timer      <= div_m1;
                    end
                end
                S_START: begin
                    if (timer == 16'd0) begin
                        state      <= S_DATA;
                        o_uart_txd <= shreg[0];
                        shreg      <= {1'b0, shreg[7:1]};
                        bit_cnt    <= '0;
                        timer      <= div_m1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_DATA: begin
                    if (timer == 16'd0) begin
                        timer <= div_m1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            state      <= S_PARITY;
                            o_uart_txd <= par_bit;
`else
                            state      <= S_STOP;
                            o_uart_txd <= 1'b1;
`endif
                        end else begin
                            o_uart_txd <= shreg[0];
                            shreg      <= {1'b0, shreg[7:1]};
                            bit_cnt    <= bit_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (timer == 16'd0) begin
                        state      <= S_STOP;
                        o_uart_txd <= 1'b1;
                        timer      <= div_m1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    o_uart_txd <= 1'b1;
                    if (timer == 16'd0) state <= S_IDLE;
                    else                timer <= timer - 16'd1;
                end
                default: begin
                    state      <= S_IDLE;
                    o_uart_txd <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit) begin
            case (reg_sel)
                2'd1:    rd_data = {16'h0, 8'(count), 4'h0, overflow, busy, empty, full};
                2'd2:    rd_data = {16'h0, divisor};
                2'd3:    rd_data = {29'h0, parity_odd, irq_en, tx_en};
                default: rd_data = '0;
            endcase
        end
    end

    assign bus.o_uart_hit     = hit;
    assign bus.o_uart_rd_data = rd_data;
    assign o_uart_irq         = irq_en & empty & ~busy;

    logic unused_bits;
    assign unused_bits = ^{bus.i_uart_addr[1:0], bus.i_uart_wr_data[31:16], bus.i_uart_byte_sel[3:2]};
endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a line monitor decodes frames and compares.
module tb_riscv_mmio_uart_tx;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_TX   = BASE;
    localparam logic [31:0] A_ST   = BASE + 32'd4;
    localparam logic [31:0] A_DIV  = BASE + 32'd8;
    localparam logic [31:0] A_CTRL = BASE + 32'd12;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
    localparam logic [31:0] CTRL_B2 = 32'h5;
`else
    localparam int NB = 10;
    localparam logic [31:0] CTRL_B2 = 32'h1;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic txd, irq;

    riscv_mmio_uart_tx_if bus ();

    riscv_mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (16'd868),
        .FIFO_DEPTH(8)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .bus       (bus),
        .o_uart_txd(txd),
        .o_uart_irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    int start_q[$];
    int frames_done = 0;
    bit mon_busy = 1'b0;
    int cur_div = 868;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int eff_div(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        bus.i_uart_addr     = a;
        bus.i_uart_wr_data  = d;
        bus.i_uart_byte_sel = sel;
        bus.i_uart_wr_en    = 1'b1;
        @(posedge clk);
        #1;
        bus.i_uart_wr_en    = 1'b0;
        bus.i_uart_byte_sel = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus.i_uart_addr = a;
        #1;
        check(name, bus.o_uart_rd_data, exp);
    endtask

    // Model: a byte enters the expected stream iff it hits TXDATA with lane 0 enabled.
    task automatic push_byte(input logic [7:0] b, input logic [3:0] sel, input logic [1:0] lo, input bit miss);
        logic [31:0] r;
        logic [31:0] a;
        r = $urandom;
        a = (miss ? BASE + 32'h10 : BASE) + {30'h0, lo};
        bus_write(a, {r[31:8], b}, sel);
        if (!miss && sel[0]) exp_q.push_back(eff_div(cur_div) * 256 + int'(b));
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || mon_busy) && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'((exp_q.size() != 0) || mon_busy), 32'h0);
        @(negedge clk);
    endtask

    // Line monitor: decodes every frame from txd and compares it to the expected stream.
    initial begin : monitor
        logic       prev;
        logic       bits [NB];
        int         item;
        int         d;
        logic [7:0] b;
        logic       bad, aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev = 1'b1;
            end else begin
                if (prev && !txd) begin
                    start_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: txd fell with nothing queued (cycle %0d)", cyc);
                    end else begin
                        mon_busy = 1'b1;
                        item = exp_q.pop_front();
                        b = item[7:0];
                        d = item >> 8;
                        bits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) bits[1+i] = b[i];
`ifdef UART_PARITY_EN
                        bits[9] = ^b;
`endif
                        bits[NB-1] = 1'b1;
                        aborted = 1'b0;
                        for (int k = 0; k < NB && !aborted; k++) begin
                            bad = 1'b0;
                            for (int s = 0; s < d && !aborted; s++) begin
                                if (k != 0 || s != 0) @(negedge clk);
                                if (!rstn) aborted = 1'b1;
                                else if (txd !== bits[k]) bad = 1'b1;
                            end
                            if (!aborted) check($sformatf("frame_bit%0d_of_%02h", k, b), 32'(bad), 32'h0);
                        end
                        if (!aborted) frames_done++;
                        mon_busy = 1'b0;
                    end
                end
                prev = rstn ? txd : 1'b1;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] r;
        int n0;
        int d;
        int n;
        bus.i_uart_addr     = '0;
        bus.i_uart_wr_en    = 1'b0;
        bus.i_uart_byte_sel = 4'h0;
        bus.i_uart_wr_data  = '0;

        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_txd", 32'(txd), 32'h1);
        check("reset_irq", 32'(irq), 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        bus_read(A_ST, 32'h2, "status_reset");
        check("hit_in_window", 32'(bus.o_uart_hit), 32'h1);
        bus_read(A_DIV, 32'd868, "div_reset");
        bus_read(A_CTRL, 32'h1, "ctrl_reset");
        bus_read(A_TX, 32'h0, "txdata_reads_zero");
        bus_read(BASE + 32'h16, 32'h0, "miss_rdata");
        check("miss_hit", 32'(bus.o_uart_hit), 32'h0);

        // Single frame 0x55 at D=4 with exact start and busy timing
        bus_write(A_DIV, 32'h0000_0004, 4'b0011);
        cur_div = 4;
        push_byte(8'h55, 4'b0001, 2'd0, 1'b0);
        @(negedge clk);
        check("txd_high_at_store", 32'(txd), 32'h1);
        bus_read(A_ST, 32'h100, "status_count1");
        @(negedge clk);
        check("txd_start_after_pop", 32'(txd), 32'h0);
        repeat (39) @(negedge clk);
        bus_read(A_ST, 32'h6, "status_busy_last_stop");
        @(negedge clk);
        bus_read(A_ST, 32'h2, "status_idle_after_frame");
        wait_drain(200, "drain_0x55");

        // Fill with tx_en=0: ninth push overflows
        bus_write(A_CTRL, 32'h0, 4'b0001);
        for (int i = 0; i < 9; i++) begin
            r = $urandom;
            bus_write(A_TX, r, 4'b0001);
            if (i < 8) exp_q.push_back(4 * 256 + int'(r[7:0]));
        end
        @(negedge clk);
        bus_read(A_ST, 32'h809, "status_full_overflow");
        bus_write(A_ST, 32'h8, 4'b0010);
        @(negedge clk);
        bus_read(A_ST, 32'h809, "overflow_kept_wrong_lane");
        bus_write(A_ST, 32'h8, 4'b0001);
        @(negedge clk);
        bus_read(A_ST, 32'h801, "overflow_cleared");

        // Enable and push in the cycle of the first pop while full
        start_q.delete();
        n0 = frames_done;
        r = $urandom;
        bus_write(A_CTRL, 32'h1, 4'b0001);
        bus_write(A_TX, r, 4'b0001);
        exp_q.push_back(4 * 256 + int'(r[7:0]));
        @(negedge clk);
        bus_read(A_ST, 32'h805, "status_push_pop_full");
        wait_drain(2000, "drain_full_fifo");
        check("frames_full_fifo", 32'(frames_done - n0), 32'd9);
        for (int i = 1; i < start_q.size(); i++)
            check("frame_period", 32'(start_q[i] - start_q[i-1]), 32'(NB * 4 + 1));
        check("irq_disabled", 32'(irq), 32'h0);

        // Interrupt behaviour
        bus_write(A_CTRL, 32'h3, 4'b0001);
        @(negedge clk);
        check("irq_idle_empty", 32'(irq), 32'h1);
        push_byte(8'hA5, 4'b0001, 2'd0, 1'b0);
        @(negedge clk);
        check("irq_drop_on_push", 32'(irq), 32'h0);
        repeat (NB * 4) @(negedge clk);
        check("irq_low_in_stop", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_rise_after_stop", 32'(irq), 32'h1);
        push_byte(8'h3C, 4'b0001, 2'd1, 1'b0);
        @(negedge clk);
        check("irq_drop_second_push", 32'(irq), 32'h0);
        wait_drain(200, "drain_irq");
        check("irq_back_high", 32'(irq), 32'h1);
        bus_write(A_CTRL, 32'h1, 4'b0001);

        // CTRL bit2 only exists with parity
        bus_write(A_CTRL, 32'h5, 4'b0001);
        @(negedge clk);
        bus_read(A_CTRL, CTRL_B2, "ctrl_bit2");
        bus_write(A_CTRL, 32'h1, 4'b0001);

        // Randomized rounds: divisor, byte lanes, address offsets and misses
        for (int rnd = 0; rnd < 8; rnd++) begin
            d = $urandom_range(0, 5);
            r = $urandom;
            bus_write(A_DIV, {r[31:16], 16'(d)}, 4'hF);
            cur_div = d;
            @(negedge clk);
            bus_read(A_DIV, 32'(d), "div_readback");
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                r = $urandom;
                case (r[9:8])
                    2'd0: push_byte(r[7:0], 4'b0001, r[11:10], r[14:12] == 3'd0);
                    2'd1: push_byte(r[7:0], 4'b0011, r[11:10], r[14:12] == 3'd0);
                    2'd2: push_byte(r[7:0], 4'b1111, r[11:10], r[14:12] == 3'd0);
                    default: push_byte(r[7:0], 4'b0010, r[11:10], r[14:12] == 3'd0);
                endcase
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_drain(1000, "drain_random");
        end

        // Reset mid-DATA aborts the frame and discards the FIFO
        bus_write(A_DIV, 32'h4, 4'b0011);
        cur_div = 4;
        push_byte(8'hC3, 4'b0001, 2'd0, 1'b0);
        push_byte(8'h18, 4'b0001, 2'd0, 1'b0);
        push_byte(8'h7E, 4'b0001, 2'd0, 1'b0);
        repeat (10) @(negedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("txd_async_reset", 32'(txd), 32'h1);
        exp_q.delete();
        cur_div = 868;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        n0 = frames_done;
        @(negedge clk);
        bus_read(A_ST, 32'h2, "status_after_reset");
        bus_read(A_DIV, 32'd868, "div_after_reset");
        repeat (60) @(negedge clk);
        check("no_residual_frame", 32'(frames_done - n0), 32'h0);
        check("txd_idle_after_reset", 32'(txd), 32'h1);

`ifdef UART_PARITY_EN
        bus_write(A_DIV, 32'h4, 4'b0011);
        cur_div = 4;
        push_byte(8'h07, 4'b0001, 2'd0, 1'b0);
        wait_drain(200, "drain_parity");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
